// File: rtl/riscy_mc_control.sv
// ---------------------------------------------------------------------------
// riscy_mc_control : multi-cycle control FSM for the riscy32 core
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module riscy_mc_control #(
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_LUI    = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  state_t state, state_next;

  logic       flag_v, flag_c, flag_z, flag_s;
  logic       taken;
  logic       bad_branch;
  logic [3:0] alu_funct_r;
  logic [3:0] alu_funct_i;

  assign flag_v = flags[0];
  assign flag_c = flags[1];
  assign flag_z = flags[2];
  assign flag_s = flags[3];

  assign alu_funct_r = {funct7b5, funct3};
  // Only SRAI uses instr[30]; any other I-type keeps bit 3 clear.
  assign alu_funct_i = {funct7b5 & (funct3 == 3'b101), funct3};

  assign bad_branch = (funct3 == 3'b010) || (funct3 == 3'b011);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = flag_z;
      3'b001:  taken = ~flag_z;
      3'b100:  taken = flag_s ^ flag_v;
      3'b101:  taken = ~(flag_s ^ flag_v);
      3'b110:  taken = ~flag_c;
      3'b111:  taken = flag_c;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_BRANCH:    state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_ERROR;
        endcase
      end
      S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR:  state_next = S_ALUWB;
      S_EXECI:  state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = bad_branch ? S_ERROR : S_FETCH;
      S_JAL:    state_next = S_ALUWB;
      S_LUI:    state_next = S_ALUWB;
      S_ERROR:  state_next = ERR_STICKY ? S_ERROR : S_FETCH;
      default:  state_next = S_ERROR;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    illegal     = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_funct_r;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_funct_i;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = taken & ~bad_branch;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_ERROR: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase

    imm_src = 3'b000;
    case (op)
      OP_SW:     imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_JAL:    imm_src = 3'b011;
      OP_LUI:    imm_src = 3'b100;
      default:   imm_src = 3'b000;
    endcase

    // Asserting reset must kill any in-flight request without waiting for a clock.
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      imm_src     = 3'b000;
      alu_control = 4'b0000;
      illegal     = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/riscy_mc_control.md
Name: riscy_mc_control

Overview:
- Multi-cycle control FSM for the riscy32 multi-cycle core. It is the initiator side of the ALU interface: it drives `alu_control[3:0]` using the ALU's encoding and consumes the ALU `flags[3:0]` to resolve branches.
- It sequences fetch, decode, execute, memory and writeback over shared PC, IR and ALUOut registers, with a ready handshake to a single unified memory port.
- Supported opcodes: lw, sw, R-type, I-type ALU, branch, jal, lui.

Parameters:
- `ERR_STICKY`, 1, 1 = ERROR state holds until reset; 0 = ERROR returns to FETCH after one cycle.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `op`  in  7  instr[6:0] from IR
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `flags`  in  4  ALU flags: [0] overflow, [1] carry, [2] zero, [3] sign
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request valid
- `mem_write`  out  1  store strobe, qualified by `mem_req`
- `adr_src`  out  1  0 = PC, 1 = ALUOut
- `ir_write`  out  1  latch IR and OldPC
- `pc_write`  out  1  update PC from result
- `reg_write`  out  1  register file write
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- `alu_src_b`  out  2  00 = rs2, 01 = imm, 10 = constant 4
- `result_src`  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result
- `imm_src`  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- `alu_control`  out  4  {funct7b5, funct3} ALU encoding
- `illegal`  out  1  high in ERROR

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- While `rst_n` = 0:
  - state = FETCH.
  - `mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write` and `illegal` are forced to 0.
  - `alu_control` = 0000; all other outputs are 0.
- Output timing:
  - Outputs are combinational from the state register, plus `mem_ready`, `funct3`, `flags` and `op` where noted.
  - The state register updates on the `clk` rising edge.
- ALU encodings driven on `alu_control`:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Funct decode:
  - R-type: `alu_control` = {`funct7b5`, `funct3`}.
  - I-type: `alu_control` = {`funct7b5` & (`funct3` == 101), `funct3`}. ADDI with instr[30] = 1 is still ADD.
- `imm_src` is decoded from `op` in every state. Unknown `op` gives 000.
- States, with outputs not listed at 0 and `alu_control` = ADD unless stated:
  - FETCH:
    - Outputs: `mem_req` = 1, `adr_src` = 0, `alu_src_a` = 00, `alu_src_b` = 10, `result_src` = 10.
    - `ir_write` = `pc_write` = `mem_ready`.
    - Stay in FETCH while `mem_ready` = 0; go to DECODE when `mem_ready` = 1.
  - DECODE:
    - Outputs: `alu_src_a` = 01, `alu_src_b` = 01. This places the branch/jump target in ALUOut.
    - Next state by `op`:
      - 0000011 or 0100011 -> MEMADR
      - 0110011 -> EXECR
      - 0010011 -> EXECI
      - 1100011 -> BRANCH
      - 1101111 -> JAL
      - 0110111 -> LUI
      - any other value -> ERROR
  - MEMADR:
    - Outputs: `alu_src_a` = 10, `alu_src_b` = 01.
    - Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD:
    - Outputs: `mem_req` = 1, `adr_src` = 1.
    - Wait for `mem_ready`, then go to MEMWB.
  - MEMWB:
    - Outputs: `result_src` = 01, `reg_write` = 1.
    - Next: FETCH.
  - MEMWR:
    - Outputs: `mem_req` = 1, `mem_write` = 1, `adr_src` = 1.
    - Wait for `mem_ready`, then go to FETCH.
  - EXECR:
    - Outputs: `alu_src_a` = 10, `alu_src_b` = 00, funct decode on `alu_control`.
    - Next: ALUWB.
  - EXECI:
    - Outputs: `alu_src_a` = 10, `alu_src_b` = 01, funct decode on `alu_control`.
    - Next: ALUWB.
  - ALUWB:
    - Outputs: `result_src` = 00, `reg_write` = 1.
    - Next: FETCH.
  - BRANCH:
    - Outputs: `alu_src_a` = 10, `alu_src_b` = 00, `alu_control` = SUB, `result_src` = 00, `pc_write` = taken.
    - Next: FETCH.
    - `funct3` of 010 or 011 goes to ERROR with `pc_write` = 0.
  - JAL:
    - Outputs: `alu_src_a` = 01, `alu_src_b` = 10, `result_src` = 00, `pc_write` = 1.
    - Next: ALUWB, which writes OldPC + 4.
  - LUI:
    - Outputs: `alu_src_a` = 11, `alu_src_b` = 01.
    - Next: ALUWB.
  - ERROR:
    - Outputs: `illegal` = 1; all enables and `mem_req` = 0.
    - Stays in ERROR if `ERR_STICKY` = 1; otherwise returns to FETCH.
- Branch "taken" is computed from the SUB flags. Carry = carry-out of a + ~b + 1, so carry = 1 means a >= b unsigned.
  - BEQ: Z
  - BNE: !Z
  - BLT: S ^ V
  - BGE: !(S ^ V)
  - BLTU: !C
  - BGEU: C
- Handshake:
  - `mem_req` is held high with address, data and control stable until the cycle `mem_ready` = 1.
  - Exactly one transfer occurs per request.
  - `mem_ready` while `mem_req` = 0 is ignored.
- Reset mid-operation: asserting `rst_n` mid-request drops `mem_req` asynchronously. Execution restarts at FETCH with no partial writes.

Test Plan:
- Reset release with `mem_ready` = 1, `op` = 0110011, `funct3` = 000, `funct7b5` = 1:
  - Cycle 0 FETCH: `ir_write` = 1, `pc_write` = 1.
  - Cycle 1 DECODE.
  - Cycle 2 EXECR: `alu_control` = 1000.
  - Cycle 3 ALUWB: `reg_write` = 1.
  - Cycle 4 back in FETCH.
- lw with `mem_ready` low for 3 cycles in MEMRD:
  - `mem_req` = 1 and `adr_src` = 1 are held all 3 cycles.
  - MEMWB follows, with `result_src` = 01 and `reg_write` = 1.
- BRANCH sweep over `funct3` {000, 001, 100, 101, 110, 111} × `flags` {0100, 0000, 1000, 1001, 0010}:
  - `pc_write` matches the taken table. Example: BLT with `flags` = 1001 gives `pc_write` = 0.
- I-type SRAI (`funct3` = 101, `funct7b5` = 1) -> `alu_control` = 1101. ADDI with `funct7b5` = 1 -> `alu_control` = 0000.
- `op` = 1111111 -> ERROR, `illegal` = 1.
  - With `ERR_STICKY` = 1, stays in ERROR for 10 cycles.
  - With `ERR_STICKY` = 0, returns to FETCH next cycle.
- sw with `rst_n` pulsed low mid-MEMWR -> `mem_req` and `mem_write` go to 0 immediately. After release, state = FETCH.
